// File: rtl/spi_xact_ctrl_if.sv
// Signal bundle between the SPI transaction sequencer and its surroundings:
// conditioned SPI inputs in, datapath strobes and status out.
interface spi_xact_ctrl_if;
  logic cs_n;
  logic sclk_posedge;
  logic sclk_negedge;
  logic sr_rw_bit;
  logic sr_shift_en;
  logic sr_load;
  logic addr_we;
  logic addr_inc;
  logic dm_we;
  logic miso_capture;
  logic miso_oe;
  logic busy;
  logic xact_done;
  logic abort;
  logic proto_err;

  // The sequencer itself
  modport slave (
    input  cs_n, sclk_posedge, sclk_negedge, sr_rw_bit,
    output sr_shift_en, sr_load, addr_we, addr_inc, dm_we,
    output miso_capture, miso_oe, busy, xact_done, abort, proto_err
  );

  // Input conditioners and datapath driving/observing the sequencer
  modport master (
    output cs_n, sclk_posedge, sclk_negedge, sr_rw_bit,
    input  sr_shift_en, sr_load, addr_we, addr_inc, dm_we,
    input  miso_capture, miso_oe, busy, xact_done, abort, proto_err
  );
endinterface

// File: rtl/spi_xact_ctrl.sv
// SPI slave transaction sequencer: counts SCLK edges, decodes {addr, rw} and
// strobes the datapath. Define SPI_BURST_EN for auto-incrementing burst access.
module spi_xact_ctrl #(
  parameter int WIDTH   = 8,
  parameter bit RW_READ = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  spi_xact_ctrl_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    LATCH_ADDR,
    READ_LOAD,
    READ_SHIFT,
    WRITE_GET,
    WRITE_STORE,
    NEXT,
    HOLD
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic             rw_reg, rw_next;
  logic             data_seen_reg, data_seen_next;
  logic             proto_err_reg, proto_err_next;
  logic             oe_reg, oe_next;

  logic             shift_en;
  logic             load_en;
  logic             addr_we_en;
  logic             addr_inc_en;
  logic             dm_we_en;
  logic             capture_en;
  logic             done_pulse;
  logic             abort_pulse;

  logic             cs_release;
  logic             last_bit;
  logic             rw_is_read;
  logic [CNT_W-1:0] bit_cnt_inc;

  assign cs_release  = (state_reg != IDLE) && bus.cs_n;
  assign last_bit    = (bit_cnt_reg == LAST_BIT);
  assign rw_is_read  = (rw_reg == RW_READ);
  assign bit_cnt_inc = last_bit ? '0 : bit_cnt_reg + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      rw_reg        <= 1'b0;
      data_seen_reg <= 1'b0;
      proto_err_reg <= 1'b0;
      oe_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      rw_reg        <= rw_next;
      data_seen_reg <= data_seen_next;
      proto_err_reg <= proto_err_next;
      oe_reg        <= oe_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    rw_next        = rw_reg;
    data_seen_next = data_seen_reg;
    proto_err_next = proto_err_reg;
    oe_next        = oe_reg;
    shift_en       = 1'b0;
    load_en        = 1'b0;
    addr_we_en     = 1'b0;
    addr_inc_en    = 1'b0;
    dm_we_en       = 1'b0;
    capture_en     = 1'b0;
    done_pulse     = 1'b0;
    abort_pulse    = 1'b0;

    if (cs_release) begin
      // Chip-select release beats any SCLK edge; a partial byte is dropped.
      state_next     = IDLE;
      bit_cnt_next   = '0;
      data_seen_next = 1'b0;
      oe_next        = 1'b0;
      done_pulse     = data_seen_reg;
      abort_pulse    = !data_seen_reg;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!bus.cs_n) begin
            state_next     = GET_ADDR;
            bit_cnt_next   = '0;
            proto_err_next = 1'b0;
            data_seen_next = 1'b0;
            oe_next        = 1'b0;
          end
        end

        GET_ADDR: begin
          if (bus.sclk_posedge) begin
            shift_en     = 1'b1;
            bit_cnt_next = bit_cnt_inc;
            if (last_bit) begin
              state_next = LATCH_ADDR;
            end
          end
        end

        LATCH_ADDR: begin
          addr_we_en = 1'b1;
          rw_next    = bus.sr_rw_bit;
          state_next = (bus.sr_rw_bit == RW_READ) ? READ_LOAD : WRITE_GET;
          if (bus.sclk_posedge) begin
            proto_err_next = 1'b1;
          end
        end

        READ_LOAD: begin
          load_en    = 1'b1;
          oe_next    = 1'b1;
          state_next = READ_SHIFT;
          if (bus.sclk_posedge) begin
            proto_err_next = 1'b1;
          end
        end

        READ_SHIFT: begin
          capture_en = bus.sclk_negedge && rw_is_read;
          if (bus.sclk_posedge) begin
            shift_en     = 1'b1;
            bit_cnt_next = bit_cnt_inc;
            if (last_bit) begin
              state_next     = NEXT;
              data_seen_next = 1'b1;
            end
          end
        end

        WRITE_GET: begin
          if (bus.sclk_posedge) begin
            shift_en     = 1'b1;
            bit_cnt_next = bit_cnt_inc;
            if (last_bit) begin
              state_next = WRITE_STORE;
            end
          end
        end

        WRITE_STORE: begin
          dm_we_en       = 1'b1;
          data_seen_next = 1'b1;
          state_next     = NEXT;
          if (bus.sclk_posedge) begin
            proto_err_next = 1'b1;
          end
        end

        NEXT: begin
          if (bus.sclk_posedge) begin
            proto_err_next = 1'b1;
          end
`ifdef SPI_BURST_EN
          addr_inc_en = 1'b1;
          state_next  = rw_is_read ? READ_LOAD : WRITE_GET;
`else
          state_next  = HOLD;
`endif
        end

        // SCLK is ignored here; the MISO enable keeps whatever it had.
        HOLD: begin
          state_next = HOLD;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign bus.sr_shift_en  = shift_en;
  assign bus.sr_load      = load_en;
  assign bus.addr_we      = addr_we_en;
  assign bus.addr_inc     = addr_inc_en;
  assign bus.dm_we        = dm_we_en;
  assign bus.miso_capture = capture_en;
  assign bus.miso_oe      = oe_reg && !bus.cs_n;
  assign bus.busy         = (state_reg != IDLE);
  assign bus.xact_done    = done_pulse;
  assign bus.abort        = abort_pulse;
  assign bus.proto_err    = proto_err_reg;

endmodule

// File: tb/tb_spi_xact_ctrl.sv
// Bench for spi_xact_ctrl: a small behavioural datapath reacts to the strobes,
// and a memory model predicts stored bytes and MISO bit streams.
module tb_spi_xact_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spi_xact_ctrl_if bus();

  spi_xact_ctrl #(.WIDTH(8), .RW_READ(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

`ifdef SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  // Datapath around the sequencer
  logic       mosi = 1'b0;
  logic       preload_en = 1'b0;
  logic [6:0] preload_addr = '0;
  logic [7:0] preload_data = '0;
  logic [7:0] sr = '0;
  logic [6:0] addr = '0;
  logic [7:0] dp_mem [128];
  logic [14:0] wr_q [$];
  logic        miso_q [$];

  logic s_shift = 0, s_load = 0, s_awe = 0, s_inc = 0, s_dwe = 0, s_cap = 0, s_mosi = 0;
  int n_awe = 0, n_dwe = 0, n_inc = 0, n_done = 0, n_abort = 0;
  int n_excl = 0, n_cs_strobe = 0, n_laa = 0;
  logic prev_awe = 1'b0;

  assign bus.sr_rw_bit = sr[0];

  // Sample strobes mid-cycle, apply them on the following rising edge
  always @(negedge clk) begin
    s_shift  <= bus.sr_shift_en;
    s_load   <= bus.sr_load;
    s_awe    <= bus.addr_we;
    s_inc    <= bus.addr_inc;
    s_dwe    <= bus.dm_we;
    s_cap    <= bus.miso_capture;
    s_mosi   <= mosi;
    n_awe    <= n_awe   + (bus.addr_we   ? 1 : 0);
    n_dwe    <= n_dwe   + (bus.dm_we     ? 1 : 0);
    n_inc    <= n_inc   + (bus.addr_inc  ? 1 : 0);
    n_done   <= n_done  + (bus.xact_done ? 1 : 0);
    n_abort  <= n_abort + (bus.abort     ? 1 : 0);
    prev_awe <= bus.addr_we;
    if (bus.sr_load && prev_awe) n_laa <= n_laa + 1;
    if ($countones({bus.sr_shift_en, bus.sr_load, bus.addr_we, bus.addr_inc,
                    bus.dm_we, bus.miso_capture}) > 1)
      n_excl <= n_excl + 1;
    if (bus.cs_n && bus.busy && (|{bus.sr_shift_en, bus.sr_load, bus.addr_we, bus.addr_inc,
                                   bus.dm_we, bus.miso_capture, bus.miso_oe}))
      n_cs_strobe <= n_cs_strobe + 1;
  end

  always @(posedge clk) begin
    if (preload_en) dp_mem[preload_addr] <= preload_data;
    if (s_shift) sr <= {sr[6:0], s_mosi};
    else if (s_load) sr <= dp_mem[addr];
    if (s_awe) addr <= sr[7:1];
    else if (s_inc) addr <= addr + 7'd1;
    if (s_dwe) begin
      dp_mem[addr] <= sr;
      wr_q.push_back({addr, sr});
    end
    if (s_cap) miso_q.push_back(sr[7]);
  end

  // Reference model and snapshot bookkeeping
  logic [7:0] mem_model [128];
  int b_awe, b_dwe, b_inc, b_done, b_abort, b_wr, b_miso, b_laa;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {bus.sr_shift_en, bus.sr_load, bus.addr_we, bus.addr_inc, bus.dm_we,
            bus.miso_capture, bus.miso_oe, bus.busy, bus.xact_done, bus.abort, bus.proto_err};
  endfunction

  function automatic logic [14:0] get_wr(input int i);
    return (i < wr_q.size()) ? wr_q[i] : 15'bx;
  endfunction

  function automatic logic [7:0] miso_byte(input int base);
    logic [7:0] v;
    for (int i = 0; i < 8; i++)
      v[7-i] = (base + i < miso_q.size()) ? miso_q[base+i] : 1'bx;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_awe = n_awe; b_dwe = n_dwe; b_inc = n_inc; b_done = n_done; b_abort = n_abort;
    b_wr = wr_q.size(); b_miso = miso_q.size(); b_laa = n_laa;
  endtask

  task automatic preload(input logic [6:0] a, input logic [7:0] d);
    preload_en = 1'b1; preload_addr = a; preload_data = d;
    mem_model[a] = d;
    tick(1);
    preload_en = 1'b0;
  endtask

  task automatic pos_pulse(input logic b);
    mosi = b;
    bus.sclk_posedge = 1'b1;
    tick(1);
    bus.sclk_posedge = 1'b0;
  endtask

  task automatic neg_pulse();
    bus.sclk_negedge = 1'b1;
    tick(1);
    bus.sclk_negedge = 1'b0;
  endtask

  task automatic spi_bit(input logic b);
    pos_pulse(b);
    tick(3);
    neg_pulse();
    tick(3);
  endtask

  task automatic spi_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) spi_bit(v[i]);
  endtask

  task automatic cs_low();
    bus.cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_high();
    bus.cs_n = 1'b1;
    tick(4);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [6:0] a;
    logic [6:0] ak;
    logic       rd;
    int         nb;
    int         eff;
    logic [7:0] d [3];
    logic [7:0] v;

    bus.cs_n = 1'b1;
    bus.sclk_posedge = 1'b0;
    bus.sclk_negedge = 1'b0;
    reset_n = 1'b0;
    #1;
    check("reset_outputs", outs(), 11'd0);
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom);
      preload(7'(i), v);
    end
    reset_n = 1'b1;
    tick(2);
    check("idle_outputs", outs(), 11'd0);

    // Reset in the middle of the command byte
    cs_low();
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    check("busy_mid_addr", bus.busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("reset_mid_addr_outputs", outs(), 11'd0);
    bus.cs_n = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    $display("xact reset_mid_addr done");

    // Single write: command 0x14 (addr 0x0A, write), data 0xA5
    snap();
    cs_low();
    spi_byte(8'h14);
    spi_byte(8'hA5);
    check("write_busy", bus.busy, 1'b1);
    cs_high();
    mem_model[7'h0A] = 8'hA5;
    check("write_addr_we", n_awe - b_awe, 1);
    check("write_dm_we", n_dwe - b_dwe, 1);
    check("write_entry", get_wr(b_wr), {7'h0A, mem_model[7'h0A]});
    check("write_done", n_done - b_done, 1);
    check("write_abort", n_abort - b_abort, 0);
    check("write_idle", bus.busy, 1'b0);
    $display("xact write addr=0a data=a5");

    // Single read of 0x3C from address 0x0A
    preload(7'h0A, 8'h3C);
    snap();
    cs_low();
    spi_byte(8'h15);
    spi_byte(8'($urandom));
    check("read_oe_before_cs", bus.miso_oe, 1'b1);
    cs_high();
    check("read_oe_after_cs", bus.miso_oe, 1'b0);
    check("read_load_after_awe", n_laa - b_laa, 1);
    check("read_miso_byte", miso_byte(b_miso), mem_model[7'h0A]);
    check("read_no_dm_we", n_dwe - b_dwe, 0);
    check("read_done", n_done - b_done, 1);
    $display("xact read addr=0a data=%02h", miso_byte(b_miso));

    // Partial data byte then release
    snap();
    cs_low();
    spi_byte(8'h14);
    for (int i = 0; i < 3; i++) spi_bit(1'b1);
    cs_high();
    check("abort_no_dm_we", n_dwe - b_dwe, 0);
    check("abort_pulse", n_abort - b_abort, 1);
    check("abort_no_done", n_done - b_done, 0);
    check("abort_idle", bus.busy, 1'b0);
    $display("xact abort partial byte");

    // Release in the very cycle the byte would be stored
    snap();
    cs_low();
    spi_byte(8'h14);
    v = 8'h5A;
    for (int i = 7; i >= 1; i--) spi_bit(v[i]);
    pos_pulse(v[0]);
    bus.cs_n = 1'b1;
    #1;
    check("store_cs_dm_we", bus.dm_we, 1'b0);
    check("store_cs_abort", bus.abort, 1'b1);
    tick(4);
    check("store_cs_no_write", n_dwe - b_dwe, 0);
    $display("xact abort at store");

    // Burst write wrapping 0x7F -> 0x00
    snap();
    cs_low();
    spi_byte(8'hFE);
    spi_byte(8'h11);
    spi_byte(8'h22);
    cs_high();
    eff = BURST ? 2 : 1;
    d[0] = 8'h11; d[1] = 8'h22;
    check("burst_write_count", wr_q.size() - b_wr, eff);
    for (int k = 0; k < eff; k++) begin
      ak = 7'h7F + 7'(k);
      mem_model[ak] = d[k];
      check("burst_write_entry", get_wr(b_wr + k), {ak, d[k]});
    end
    check("burst_addr_inc", n_inc - b_inc, BURST ? eff : 0);
    check("burst_done", n_done - b_done, 1);
    $display("xact burst write addr=7f bytes=%0d", eff);

    // SCLK posedge landing in the address-latch cycle
    snap();
    cs_low();
    v = 8'h14;
    for (int i = 7; i >= 1; i--) spi_bit(v[i]);
    pos_pulse(v[0]);
    bus.sclk_posedge = 1'b1;
    #1;
    check("proto_latch_no_shift", bus.sr_shift_en, 1'b0);
    check("proto_latch_addr_we", bus.addr_we, 1'b1);
    tick(1);
    bus.sclk_posedge = 1'b0;
    check("proto_err_set", bus.proto_err, 1'b1);
    tick(3);
    neg_pulse();
    tick(3);
    cs_high();
    check("proto_err_sticky", bus.proto_err, 1'b1);
    check("proto_abort", n_abort - b_abort, 1);
    bus.cs_n = 1'b0;
    tick(1);
    check("proto_err_cleared", bus.proto_err, 1'b0);
    cs_high();
    $display("xact protocol error injected");

    // Randomised transactions against the memory model
    for (int t = 0; t < 16; t++) begin
      a  = 7'($urandom_range(0, 127));
      rd = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      eff = BURST ? nb : 1;
      snap();
      cs_low();
      spi_byte({a, rd});
      for (int k = 0; k < nb; k++) begin
        d[k] = 8'($urandom);
        spi_byte(d[k]);
      end
      cs_high();
      if (rd) begin
        for (int k = 0; k < eff; k++) begin
          ak = a + 7'(k);
          check("rand_read_byte", miso_byte(b_miso + 8 * k), mem_model[ak]);
        end
        check("rand_read_no_write", wr_q.size() - b_wr, 0);
      end else begin
        for (int k = 0; k < eff; k++) begin
          ak = a + 7'(k);
          mem_model[ak] = d[k];
          check("rand_write_entry", get_wr(b_wr + k), {ak, d[k]});
        end
        check("rand_write_count", wr_q.size() - b_wr, eff);
      end
      check("rand_done", n_done - b_done, 1);
      check("rand_abort", n_abort - b_abort, 0);
      check("rand_addr_inc", n_inc - b_inc, BURST ? eff : 0);
      $display("xact rand %0d: addr=%02h rw=%0d bytes=%0d", t, a, rd, nb);
    end

    check("strobe_exclusive", n_excl, 0);
    check("no_strobe_on_cs_rise", n_cs_strobe, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_xact_ctrl.md
Name: spi_xact_ctrl

Overview:
Transaction sequencer for the SPI slave datapath: shift register, address latch, data memory and MISO output register/buffer. It counts SCLK edges and decodes the 8-bit command byte {addr[6:0], rw}. It generates single-cycle strobes that load, shift, latch, store and drive MISO, and it aborts cleanly on chip-select release. All inputs are already synchronised and edge-detected by the input conditioners.

Parameters:
WIDTH, 8, bits per SPI byte and shift register width; bit counter is clog2(WIDTH) wide.
RW_READ, 1, value of the rw bit (last bit of the command byte) that selects a read.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset_n  input  1  asynchronous active-low reset.
cs_n  input  1  conditioned chip select, active low.
sclk_posedge  input  1  one-clk pulse on conditioned SCLK rising edge.
sclk_negedge  input  1  one-clk pulse on conditioned SCLK falling edge.
sr_rw_bit  input  1  shift register parallelOut[0]; valid in LATCH_ADDR.
sr_shift_en  output  1  shift register shifts one bit this cycle.
sr_load  output  1  shift register parallel-loads memory read data this cycle.
addr_we  output  1  address latch captures parallelOut[WIDTH-1:1].
addr_inc  output  1  address latch increments by 1, wrapping modulo 2^(WIDTH-1).
dm_we  output  1  data memory write strobe.
miso_capture  output  1  MISO output register captures serialOut.
miso_oe  output  1  MISO buffer enable.
busy  output  1  high in any state other than IDLE.
xact_done  output  1  one-cycle pulse when cs_n rises after at least one complete data byte.
abort  output  1  one-cycle pulse when cs_n rises with a partial byte or no data byte.
proto_err  output  1  sticky flag for an SCLK edge in a non-shift state; cleared on cs_n fall.

Behaviour:
- Reset (async, reset_n=0): state IDLE, bit_cnt=0, rw=0, data_seen=0. All outputs 0.
- SPI mode 0. Master samples on posedge; slave updates MISO on negedge. Every counted sclk_posedge asserts sr_shift_en in the same cycle and increments bit_cnt, which wraps to 0 after WIDTH-1.
- States:
  - IDLE: on cs_n=0, go to GET_ADDR; bit_cnt=0, proto_err=0.
  - GET_ADDR: shift on posedges. On the WIDTH-th posedge, go to LATCH_ADDR.
  - LATCH_ADDR (1 cycle): addr_we=1; rw latched from sr_rw_bit. If rw==RW_READ, go to READ_LOAD; else go to WRITE_GET.
  - READ_LOAD (1 cycle): sr_load=1; go to READ_SHIFT. miso_oe=1 from READ_SHIFT onward.
  - READ_SHIFT: shift on posedges; miso_capture=1 on every negedge, including the first negedge after load, which presents data bit WIDTH-1. After WIDTH posedges, go to NEXT.
  - WRITE_GET: shift on posedges. After WIDTH posedges, go to WRITE_STORE.
  - WRITE_STORE (1 cycle): dm_we=1, data_seen=1; go to NEXT.
  - NEXT (1 cycle): behaviour defined under Optional Feature.
  - HOLD: ignore SCLK with no proto_err and no strobes; miso_oe stays at its prior value; wait for cs_n=1.
- data_seen is also set at the end of READ_SHIFT.
- Any state except IDLE, on cs_n=1:
  - go to IDLE next cycle; all strobes deasserted that cycle; partial byte discarded, so no dm_we.
  - pulse xact_done if data_seen, else pulse abort.
- Timing: SCLK half-period must be at least 4 clk. A sclk_posedge landing in LATCH_ADDR, READ_LOAD, WRITE_STORE or NEXT is not counted or shifted and sets proto_err.
- Priority in the same cycle: reset > cs_n rise > SCLK edge.
- Strobes are mutually exclusive, except sr_shift_en with miso_oe.

Optional Feature:
SPI_BURST_EN defined:
- NEXT pulses addr_inc, then goes to READ_LOAD if rw is read, else to WRITE_GET.
- Bursts are unbounded; the address wraps 7'h7F -> 7'h00.
SPI_BURST_EN undefined:
- NEXT goes to HOLD.
- addr_inc is tied 0.

Test Plan:
- Reset mid-GET_ADDR (after 5 posedges) -> all outputs 0 immediately; next cs_n fall starts a fresh GET_ADDR with bit_cnt=0.
- Write: cs_n=0, command 0x14 (addr 0x0A, write), data 0xA5, cs_n=1 -> one addr_we, one dm_we with shift register = 0xA5 and address 0x0A, xact_done pulse, abort=0.
- Read: memory[0x0A]=0x3C, command 0x15 (read) -> sr_load one cycle after addr_we; MISO presents 0,0,1,1,1,1,0,0 on successive negedges; miso_oe=1 until cs_n rises.
- Abort: command 0x14 then 3 data posedges, cs_n=1 -> no dm_we, abort pulse, state IDLE, busy=0.
- Burst (SPI_BURST_EN): command 0xFE (addr 0x7F, write), data 0x11 then 0x22 -> dm_we at 0x7F, addr_inc, dm_we at 0x00. Without the macro: only one dm_we, and the second byte is ignored.
- Protocol error: posedge injected in LATCH_ADDR -> proto_err=1, no sr_shift_en in that cycle; proto_err cleared at next cs_n fall.
